// File: rtl/mua_pkg.sv
// Shared definitions for the MUA frame packer.
//   MUA_W      width of a stream word (header and body alike)
//   HDR_MAGIC  constant upper half of every header word
//   SEQ_W      width of the frame sequence number carried in the header
//   DROP_W     width of the saturating dropped-frame counter
//   rd_state_e read-side FSM states
package mua_pkg;

  localparam int          MUA_W     = 32;
  localparam int          SEQ_W     = 16;
  localparam int          DROP_W    = 16;
  localparam logic [15:0] HDR_MAGIC = 16'hA5A5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } rd_state_e;

endpackage

// File: rtl/mua_sync_fifo.sv
// Single-clock show-ahead FIFO with a registered occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   wr_en      : push wr_data (ignored when full)
//   rd_en      : pop the head (ignored when empty)
//   rd_data    : current head word, valid whenever empty is low
//   count      : words stored, updated at the clock edge
//   empty/full : derived from count
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module mua_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mua_frame_packer.sv
// Groups the always-valid MUA word stream into frames of N_CH words and emits
// each frame on an AXI4-Stream master as one header word {A5A5, seq} followed
// by N_CH body words, TLAST on the final body word. Whole frames are buffered
// before they become readable; frames that do not fit are dropped and counted.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid, in_data : input word strobe and data (never stalled)
//   out_tvalid/tready/tdata/tlast : AXIS master, registered outputs
//   clr_stat          : pulse clearing overflow and drop_cnt
//   overflow          : sticky flag, set on any dropped frame
//   drop_cnt          : dropped-frame count, saturating
// Handshake: a beat transfers on a clock edge where out_tvalid && out_tready;
// once out_tvalid is high, tdata/tlast hold until that transfer happens.
module mua_frame_packer
  import mua_pkg::*;
#(
  parameter int N_CH       = 160,
  parameter int FIFO_DEPTH = 512,
  parameter int SEQ_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [MUA_W-1:0]  in_data,
  output logic              out_tvalid,
  input  logic              out_tready,
  output logic [MUA_W-1:0]  out_tdata,
  output logic              out_tlast,
  input  logic              clr_stat,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int IDX_W  = $clog2(N_CH);
  localparam int DCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SCNT_W = $clog2(SEQ_DEPTH) + 1;

  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_CH - 1);
  // Highest pre-cycle occupancy that still leaves room for a whole frame.
  localparam logic [DCNT_W-1:0] ACCEPT_MAX = DCNT_W'(FIFO_DEPTH - N_CH);

  // ---------------- write side ----------------
  logic [IDX_W-1:0]  wr_idx;
  logic [SEQ_W-1:0]  wr_seq;
  logic              drop_hold;
  logic [DROP_W-1:0] drop_cnt_q;

  logic [DCNT_W-1:0] data_count;
  logic              data_empty;
  logic              data_full;
  logic [MUA_W-1:0]  data_head;
  logic [SCNT_W-1:0] seq_count;
  logic              seq_empty;
  logic              seq_full;
  logic [SEQ_W-1:0]  seq_head;

  logic idx_first;
  logic idx_last;
  logic accept_now;
  logic frame_drop;
  logic data_wr;
  logic seq_wr;
  logic drop_event;
  logic [DROP_W-1:0] drop_base;

  assign idx_first  = (wr_idx == '0);
  assign idx_last   = (wr_idx == LAST_IDX);
  assign accept_now = (data_count <= ACCEPT_MAX) && !seq_full;
  // The decision taken on word 0 is held for the rest of the frame.
  assign frame_drop = idx_first ? !accept_now : drop_hold;
  assign data_wr    = in_valid && !frame_drop;
  // Committing the last body word and its sequence number in the same cycle
  // is what makes a frame visible to the read side only once it is complete.
  assign seq_wr     = in_valid && idx_last && !frame_drop;
  assign drop_event = in_valid && idx_first && !accept_now;
  // A clear coincident with a drop restarts the count at one.
  assign drop_base  = clr_stat ? '0 : drop_cnt_q;
  assign drop_cnt   = drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx    <= '0;
      wr_seq    <= '0;
      drop_hold <= 1'b0;
    end else if (in_valid) begin
      if (idx_first) drop_hold <= !accept_now;
      wr_idx <= idx_last ? '0 : wr_idx + IDX_W'(1);
      if (idx_last) wr_seq <= wr_seq + SEQ_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop_event) begin
      overflow   <= 1'b1;
      drop_cnt_q <= (drop_base == '1) ? drop_base : drop_base + DROP_W'(1);
    end else if (clr_stat) begin
      overflow   <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

  // ---------------- buffers ----------------
  logic data_pop;
  logic seq_pop;

  mua_sync_fifo #(.W(MUA_W), .DEPTH(FIFO_DEPTH)) u_data_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (data_wr),
    .wr_data (in_data),
    .rd_en   (data_pop),
    .rd_data (data_head),
    .count   (data_count),
    .empty   (data_empty),
    .full    (data_full)
  );

  mua_sync_fifo #(.W(SEQ_W), .DEPTH(SEQ_DEPTH)) u_seq_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (seq_wr),
    .wr_data (wr_seq),
    .rd_en   (seq_pop),
    .rd_data (seq_head),
    .count   (seq_count),
    .empty   (seq_empty),
    .full    (seq_full)
  );

  logic fifo_unused;
  assign fifo_unused = ^{data_full, seq_count};

  // ---------------- read FSM ----------------
  // The FSM chooses the next word to load into the output register; a load
  // is allowed whenever the register is empty or its beat transfers this cycle.
  rd_state_e        state;
  rd_state_e        next_state;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] rd_idx_next;
  logic             load_ok;
  logic             load;
  logic [MUA_W-1:0] load_data;
  logic             load_last;

  assign load_ok = !out_tvalid || out_tready;

  always_comb begin
    next_state  = state;
    rd_idx_next = rd_idx;
    load        = 1'b0;
    load_data   = '0;
    load_last   = 1'b0;
    seq_pop     = 1'b0;
    data_pop    = 1'b0;
    case (state)
      IDLE: begin
        if (!seq_empty) next_state = HDR;
      end
      HDR: begin
        if (load_ok) begin
          load        = 1'b1;
          load_data   = {HDR_MAGIC, seq_head};
          seq_pop     = 1'b1;
          rd_idx_next = '0;
          next_state  = BODY;
        end
      end
      BODY: begin
        // data_empty cannot be high here for a committed frame; the guard
        // keeps a corrupted pointer from emitting garbage.
        if (load_ok && !data_empty) begin
          load      = 1'b1;
          load_data = data_head;
          data_pop  = 1'b1;
          if (rd_idx == LAST_IDX) begin
            load_last   = 1'b1;
            rd_idx_next = '0;
            next_state  = seq_empty ? IDLE : HDR;
          end else begin
            rd_idx_next = rd_idx + IDX_W'(1);
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rd_idx <= '0;
    end else begin
      state  <= next_state;
      rd_idx <= rd_idx_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tlast  <= 1'b0;
    end else if (load) begin
      out_tvalid <= 1'b1;
      out_tdata  <= load_data;
      out_tlast  <= load_last;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end
  end

endmodule
